spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/sonata_pkg.sv | 25 ++
 rtl/spi_arbiter_shifter.sv | 95 +++++++++
 rtl/spi_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonata_pkg.sv
//------------------------------------------------------------------------------
// Module   : sonata_pkg
// Purpose  : Shared types and constants for the SPI arbiter slice.
//            Holds the arbiter state encoding and the bits-per-byte constant.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sonata_pkg;

  // Bits shifted per SPI byte and the counter width needed to index them.
  localparam int unsigned BitCount = 8;
  localparam int unsigned BitCntW  = $clog2(BitCount);

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LOCKED  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage : sonata_pkg

`default_nettype wire

// File: rtl/spi_arbiter_shifter.sv
//------------------------------------------------------------------------------
// Module   : spi_arbiter_shifter
// Purpose  : SPI mode-0 byte engine: SCK divider plus TX/RX shift registers.
//            A start pulse loads the TX byte and divider; eight bits are
//            shifted MSB first and done is raised during the final cycle of
//            the last SCK high phase (i.e. coincident with the 8th fall).
// Ports    : clk_i, rst_ni     - clock, async active-low reset
//            start             - load tx_byte/div and begin a byte
//            tx_byte           - byte to transmit
//            div               - SCK half-period in clk_i cycles, minus 1
//            cipo              - SPI data in (sampled on SCK rise)
//            sck, copi         - SPI clock (idles low) and data out
//            done              - final-fall strobe; rx_byte is complete
//            rx_byte           - received byte
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_arbiter_shifter
  import sonata_pkg::*;
#(
  parameter int unsigned ClkDivW = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start,
  input  logic [BitCount-1:0] tx_byte,
  input  logic [ClkDivW-1:0]  div,
  input  logic                cipo,
  output logic                sck,
  output logic                copi,
  output logic                done,
  output logic [BitCount-1:0] rx_byte
);

  localparam logic [BitCntW-1:0] LastBit = BitCntW'(BitCount - 1);

  logic                active;
  logic                sck_q;
  logic [ClkDivW-1:0]  div_q;
  logic [ClkDivW-1:0]  phase_cnt;
  logic [BitCntW-1:0]  bit_cnt;
  logic [BitCount-1:0] tx_sr;
  logic [BitCount-1:0] rx_sr;
  logic                phase_end;

  assign phase_end = active && (phase_cnt == div_q);
  assign done      = phase_end && sck_q && (bit_cnt == LastBit);
  assign sck       = sck_q;
  // MSB of the TX register is on the wire from the load onward, so it is
  // settled for a full low phase before the first rise.
  assign copi      = tx_sr[BitCount-1];
  assign rx_byte   = rx_sr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active    <= 1'b0;
      sck_q     <= 1'b0;
      div_q     <= '0;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
    end else if (start) begin
      active    <= 1'b1;
      sck_q     <= 1'b0;
      div_q     <= div;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      tx_sr     <= tx_byte;
    end else if (active) begin
      if (phase_end) begin
        phase_cnt <= '0;
        if (!sck_q) begin
          // Rising edge: capture CIPO.
          sck_q <= 1'b1;
          rx_sr <= {rx_sr[BitCount-2:0], cipo};
        end else begin
          // Falling edge: present the next TX bit (zero-fill so COPI rests low).
          sck_q   <= 1'b0;
          tx_sr   <= {tx_sr[BitCount-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LastBit) begin
            active <= 1'b0;
          end
        end
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end
    end
  end

endmodule : spi_arbiter_shifter

`default_nettype wire

// File: rtl/spi_arbiter.sv
//------------------------------------------------------------------------------
// Module   : spi_arbiter
// Purpose  : Round-robin arbiter sharing one SPI mode-0 bus among NumReq
//            byte-stream requesters, with per-requester chip selects and
//            bus locking between bytes of a multi-byte transaction.
// Ports    : clk_i, rst_ni      - clock, async active-low reset
//            div_i              - SCK half-period minus 1 (latched per byte)
//            req_valid_i/data/last, req_ready_o - per-requester byte handshake
//            rsp_valid_o, rsp_data_o - RX byte pulse (per owner) and data
//            grant_o, busy_o    - current owner (one-hot), not-idle flag
//            timeout_o          - lock-timeout pulse
//            sck_o, copi_o, cipo_i, cs_no - SPI bus
// Config   : SPI_ARBITER_TIMEOUT_EN - when defined, an idle LOCKED bus is
//            force-released after TimeoutCycles; otherwise timeout_o is 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_arbiter
  import sonata_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned ClkDivW       = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ClkDivW-1:0]       div_i,
  input  logic [NumReq-1:0]        req_valid_i,
  input  logic [NumReq-1:0][7:0]   req_data_i,
  input  logic [NumReq-1:0]        req_last_i,
  output logic [NumReq-1:0]        req_ready_o,
  output logic [NumReq-1:0]        rsp_valid_o,
  output logic [7:0]               rsp_data_o,
  output logic [NumReq-1:0]        grant_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic                     sck_o,
  output logic                     copi_o,
  input  logic                     cipo_i,
  output logic [NumReq-1:0]        cs_no
);

  localparam int unsigned        IdxW    = $clog2(NumReq);
  localparam logic [IdxW-1:0]    LastIdx = IdxW'(NumReq - 1);
  localparam logic [IdxW:0]      NumReqW = (IdxW + 1)'(NumReq);

  arb_state_e          state;
  logic [IdxW-1:0]     owner;
  logic [IdxW-1:0]     ptr;
  logic                last_q;
  logic [ClkDivW-1:0]  div_q;
  logic [ClkDivW-1:0]  rel_cnt;

  logic [IdxW:0]       cand;
  logic                win_found;
  logic [IdxW-1:0]     win_idx;
  logic [NumReq-1:0]   win_onehot;
  logic [IdxW-1:0]     sel;
  logic                accept;
  logic                shift_done;
  logic [7:0]          rx_byte;

`ifdef SPI_ARBITER_TIMEOUT_EN
  localparam int unsigned     TmoW    = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
  logic [TmoW-1:0] tmo_cnt;
  logic            timeout_q;
  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout_o          = 1'b0;
`endif

  // Round-robin search starting at ptr; ptr + k is folded back into range
  // by one subtraction since it never reaches 2*NumReq.
  always_comb begin
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, ptr} + (IdxW + 1)'(k);
      if (cand >= NumReqW) begin
        cand = cand - NumReqW;
      end
      if (!win_found && req_valid_i[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // Byte acceptance: arbitration winner in IDLE, only the owner in LOCKED.
  always_comb begin
    sel    = win_idx;
    accept = 1'b0;
    case (state)
      IDLE:   accept = win_found;
      LOCKED: begin
        sel    = owner;
        accept = req_valid_i[owner];
      end
      default: ;
    endcase
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[sel] = 1'b1;
    end
  end

  spi_arbiter_shifter #(
    .ClkDivW (ClkDivW)
  ) u_shifter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start   (accept),
    .tx_byte (req_data_i[sel]),
    .div     (div_i),
    .cipo    (cipo_i),
    .sck     (sck_o),
    .copi    (copi_o),
    .done    (shift_done),
    .rx_byte (rx_byte)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= '0;
      last_q      <= 1'b0;
      div_q       <= '0;
      rel_cnt     <= '0;
      cs_no       <= '1;
      grant_o     <= '0;
      busy_o      <= 1'b0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
`ifdef SPI_ARBITER_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_o <= '0;
`ifdef SPI_ARBITER_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_found) begin
            owner   <= win_idx;
            grant_o <= win_onehot;
            cs_no   <= ~win_onehot;
            last_q  <= req_last_i[win_idx];
            div_q   <= div_i;
            busy_o  <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (shift_done) begin
            rsp_valid_o <= grant_o;
            rsp_data_o  <= rx_byte;
            if (last_q) begin
              state   <= RELEASE;
              cs_no   <= '1;
              rel_cnt <= '0;
            end else begin
              state   <= LOCKED;
`ifdef SPI_ARBITER_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
        end

        LOCKED: begin
          if (req_valid_i[owner]) begin
            last_q <= req_last_i[owner];
            div_q  <= div_i;
            state  <= SHIFT;
          end
`ifdef SPI_ARBITER_TIMEOUT_EN
          else if (tmo_cnt == TmoLast) begin
            timeout_q <= 1'b1;
            state     <= RELEASE;
            cs_no     <= '1;
            rel_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        RELEASE: begin
          // CS deselect gap of div_q+1 cycles, then hand priority onward.
          if (rel_cnt == div_q) begin
            state   <= IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
            ptr     <= (owner == LastIdx) ? '0 : owner + 1'b1;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : spi_arbiter

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_spi_arbiter
// Purpose  : Scoreboard testbench for spi_arbiter. Directed stimulus pushes
//            expected bytes; a negedge monitor models the SPI slave and
//            checks each rsp_valid_o pulse against the queue.
// Config   : SPI_ARBITER_TIMEOUT_EN selects the lock-timeout scenario.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_arbiter;

  localparam int NR = 2;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [7:0]         div_i;
  logic [NR-1:0]      req_valid_i;
  logic [NR-1:0][7:0] req_data_i;
  logic [NR-1:0]      req_last_i;
  logic [NR-1:0]      req_ready_o;
  logic [NR-1:0]      rsp_valid_o;
  logic [7:0]         rsp_data_o;
  logic [NR-1:0]      grant_o;
  logic               busy_o;
  logic               timeout_o;
  logic               sck_o;
  logic               copi_o;
  logic               cipo_i;
  logic [NR-1:0]      cs_no;

  spi_arbiter #(
    .NumReq        (NR),
    .ClkDivW       (8),
    .TimeoutCycles (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .div_i       (div_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .sck_o       (sck_o),
    .copi_o      (copi_o),
    .cipo_i      (cipo_i),
    .cs_no       (cs_no)
  );

  always #5 clk_i = ~clk_i;

  int vecs = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         owner;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [1:0] cs;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] slv_q[$];
  exp_t       mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_byte(input int owner, input logic [7:0] tx, input logic [7:0] rx,
                             input logic [1:0] cs, input int lat);
    exp_t e;
    e.owner = owner; e.tx = tx; e.rx = rx; e.cs = cs; e.lat = lat;
    exp_q.push_back(e);
    slv_q.push_back(rx);
  endtask

  // Slave model and scoreboard monitor.
  logic       sck_prev;
  int         nfall;
  logic [7:0] slv_byte;
  logic [7:0] copi_sr;
  int         t_start;

  assign cipo_i = (nfall < 8) ? slv_byte[3'(7 - nfall)] : 1'b0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      sck_prev <= 1'b0;
      nfall    <= 0;
      slv_byte <= 8'h00;
      copi_sr  <= 8'h00;
      t_start  <= 0;
    end else begin
      sck_prev <= sck_o;
      if (|req_ready_o) begin
        t_start <= cyc;
        nfall   <= 0;
        copi_sr <= 8'h00;
        if (slv_q.size() > 0) slv_byte <= slv_q.pop_front();
        else                  slv_byte <= 8'h00;
      end else begin
        if (sck_prev && !sck_o) nfall <= nfall + 1;
        if (!sck_prev && sck_o) copi_sr <= {copi_sr[6:0], copi_o};
      end
      if (|rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_owner", 32'(rsp_valid_o), 32'd1 << mon_e.owner);
          chk("rsp_data", 32'(rsp_data_o), 32'(mon_e.rx));
          chk("copi_byte", 32'(copi_sr), 32'(mon_e.tx));
          chk("latency", cyc - t_start, mon_e.lat);
          chk("cs_at_rsp", 32'(cs_no), 32'(mon_e.cs));
        end
      end
    end
  end

  task automatic send(input int idx, input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i[idx] = 1'b1;
    req_data_i[idx]  = d;
    req_last_i[idx]  = l;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk_i);
      if (req_ready_o[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ready_wait", 32'(ok), 32'd1);
    @(posedge clk_i); #1;
    req_valid_i[idx] = 1'b0;
    req_data_i[idx]  = 8'h00;
    req_last_i[idx]  = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk_i); #1;
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    int rsp_cnt;
    logic prev;
    logic hi;
    int n;

    rst_ni      = 1'b0;
    div_i       = 8'd0;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;

    // Reset state.
    repeat (2) @(negedge clk_i);
    chk("rst_cs_no", 32'(cs_no), 32'h3);
    chk("rst_sck", 32'(sck_o), 32'd0);
    chk("rst_copi", 32'(copi_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Contention from reset: req0 first, then req1.
    div_i = 8'd0;
    expect_byte(0, 8'h5A, 8'hC3, 2'b11, 17);
    expect_byte(1, 8'h96, 8'h69, 2'b11, 17);
    fork
      send(0, 8'h5A, 1'b1);
      send(1, 8'h96, 1'b1);
    join
    drain();

    // Single request, div=1: 2-cycle phases, 1 + 16*2 cycles to response.
    div_i = 8'd1;
    expect_byte(0, 8'hA5, 8'h3C, 2'b11, 33);
    send(0, 8'hA5, 1'b1);
    drain();
    @(negedge clk_i);
    @(negedge clk_i); #1;
    chk("cs0_high_after_rsp", 32'(cs_no[0]), 32'd1);

    // Lock: req1 holds the bus for two bytes while req0 waits.
    div_i = 8'd0;
    expect_byte(1, 8'h11, 8'hEE, 2'b01, 17);
    expect_byte(1, 8'h22, 8'hDD, 2'b11, 17);
    expect_byte(0, 8'h80, 8'h01, 2'b11, 17);
    fork
      begin
        send(1, 8'h11, 1'b0);
        send(1, 8'h22, 1'b1);
      end
      send(0, 8'h80, 1'b1);
    join
    drain();

    // Mid-byte reset after 3 SCK rises.
    slv_q.push_back(8'h55);
    send(0, 8'hF0, 1'b1);
    rises = 0;
    prev  = sck_o;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_i); #1;
      if (!prev && sck_o) rises++;
      prev = sck_o;
      if (rises == 3) break;
    end
    chk("rise_wait", rises, 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("abort_cs_no", 32'(cs_no), 32'h3);
    chk("abort_sck", 32'(sck_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    slv_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    chk("abort_rsp_data", 32'(rsp_data_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni  = 1'b1;
    rsp_cnt = 0;
    repeat (40) begin
      @(negedge clk_i); #1;
      if (|rsp_valid_o) rsp_cnt++;
    end
    chk("abort_no_rsp", rsp_cnt, 32'd0);

    // Byte with last=0 and no follow-up.
    expect_byte(1, 8'h37, 8'h48, 2'b01, 17);
    send(1, 8'h37, 1'b0);
    drain();
`ifdef SPI_ARBITER_TIMEOUT_EN
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i); #1;
      if (timeout_o) begin
        n = k;
        break;
      end
    end
    chk("timeout_delay", n, 32'd16);
    chk("timeout_cs_no", 32'(cs_no), 32'h3);
    @(negedge clk_i); #1;
    chk("timeout_pulse_width", 32'(timeout_o), 32'd0);
    chk("timeout_busy_cleared", 32'(busy_o), 32'd0);
`else
    hi = 1'b0;
    n  = 0;
    repeat (40) begin
      @(negedge clk_i); #1;
      hi = hi | timeout_o;
    end
    chk("timeout_tied_low", 32'(hi), 32'd0);
    chk("locked_cs_held", 32'(cs_no), 32'h1);
    chk("locked_busy", 32'(busy_o), 32'd1);
    expect_byte(1, 8'h38, 8'h49, 2'b11, 17);
    send(1, 8'h38, 1'b1);
    drain();
`endif

    repeat (4) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule : tb_spi_arbiter

`default_nettype wire
